load_store_unit: RTL

- Sits directly upstream of the data memory, between the execute stage and the memory's WE/BE/A/WD/RD port.
- Converts byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests into the memory's word-indexed, byte-lane protocol.
- Extracts, aligns and sign/zero-extends load data, and reports misaligned or out-of-range accesses.
- Uses a valid/ready request handshake and a valid/ready response handshake. One transaction is in flight at a time.

---
 rtl/load_store_unit.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: byte-addressed LB..SW requests to a word-indexed,
// byte-lane data memory port, with a valid/ready request/response pair.
module load_store_unit #(
  parameter int MEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_WE,
  output logic [3:0]  mem_BE,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  input  logic [31:0] mem_RD
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] WR1  = 3'd1;
  localparam logic [2:0] WR2  = 3'd2;
  localparam logic [2:0] RD   = 3'd3;
  localparam logic [2:0] RESP = 3'd4;

  localparam logic [31:0] DEPTH = 32'(MEM_DEPTH);

  logic [2:0]  state;
  logic        we_q;
  logic        sgn_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        bad_size;
  logic        bad_half;
  logic        bad_word;
  logic        oor;
  logic        err;

  logic [7:0]  rb;
  logic [15:0] rh;
  logic [31:0] ld;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign mem_A     = {2'b00, addr_q[31:2]};

  assign bad_size = (req_size == 2'b11);
  assign bad_half = (req_size == 2'b01) && req_addr[0];
  assign bad_word = (req_size == 2'b10) && (|req_addr[1:0]);
  assign oor      = ({2'b00, req_addr[31:2]} >= DEPTH);
  assign err      = bad_size | bad_half | bad_word | oor;

  always_comb begin
    rb = mem_RD[{addr_q[1:0], 3'b000} +: 8];
    rh = addr_q[1] ? mem_RD[31:16] : mem_RD[15:0];
    ld = mem_RD;
    unique case (size_q)
      2'b00:   ld = {{24{sgn_q & rb[7]}}, rb};
      2'b01:   ld = {{16{sgn_q & rh[15]}}, rh};
      default: ld = mem_RD;
    endcase
  end

  // Halves go out as two single-lane writes: low byte, then high byte.
  always_comb begin
    mem_WE = 1'b0;
    mem_BE = 4'b0000;
    mem_WD = 32'h0;
    unique case (state)
      WR1: begin
        mem_WE = 1'b1;
        if (size_q == 2'b10) begin
          mem_BE = 4'b1111;
          mem_WD = wdata_q;
        end else begin
          mem_BE = 4'b0001 << addr_q[1:0];
          mem_WD = {24'h0, wdata_q[7:0]};
        end
      end
      WR2: begin
        mem_WE = 1'b1;
        mem_BE = 4'b0001 << (addr_q[1:0] + 2'd1);
        mem_WD = {24'h0, wdata_q[15:8]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      sgn_q     <= 1'b0;
      size_q    <= 2'b00;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            sgn_q     <= req_signed;
            size_q    <= req_size;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            rsp_rdata <= 32'h0;
            rsp_err   <= err;
            if (err)
              state <= RESP;
            else if (req_we)
              state <= WR1;
            else
              state <= RD;
          end
        end
        WR1: begin
          state <= (size_q == 2'b01) ? WR2 : RESP;
        end
        WR2: begin
          state <= RESP;
        end
        RD: begin
          rsp_rdata <= ld;
          rsp_err   <= 1'b0;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
